aes_key_schedule: RTL and testbench

Parametrised AES key schedule supporting K = 128/192/256.
- Expands one 32-bit schedule word per cycle into an internal store of all NR+1 round keys.
- Streams the round keys over a valid/ready interface in encrypt order (round 0..NR) or decrypt order (round NR..0).
- Replays the stored schedule on request without re-expansion.
- Sits between key input and the cipher/inverse-cipher round datapath; successor to the per-round, encrypt-only expander.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_kx_word.sv | 30 +++
 rtl/aes_key_schedule.sv | 163 ++++++++++++++++
 tb/tb_aes_key_schedule.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// aes_pkg: shared AES key-schedule types, S-box and GF(2^8) helpers.
// Revision: 1.0
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_GEN    = 2'd1,
    KS_STREAM = 2'd2
  } ks_state_t;

  typedef enum logic [1:0] {
    ROTSUB_RCON = 2'd0,
    SUB_ONLY    = 2'd1,
    PLAIN       = 2'd2
  } kx_mode_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nk_of(input int k);
    return k / 32;
  endfunction

  function automatic int nr_of(input int k);
    return k / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_kx_word.sv
`default_nettype none
// aes_kx_word: combinational generator of one AES key-schedule word.
// Revision: 1.0
module aes_kx_word
  import aes_pkg::*;
(
  input  word_t      w_im1,
  input  word_t      w_imnk,
  input  logic [7:0] rcon,
  input  kx_mode_t   mode,
  output word_t      w_i
);

  word_t w_sub_in;
  word_t w_sub;
  word_t w_temp;

  always_comb begin
    w_sub_in = (mode == ROTSUB_RCON) ? rot_word(w_im1) : w_im1;
    w_sub    = sub_word(w_sub_in);
    case (mode)
      ROTSUB_RCON: w_temp = w_sub ^ {rcon, 24'h0};
      SUB_ONLY:    w_temp = w_sub;
      default:     w_temp = w_im1;
    endcase
    w_i = w_imnk ^ w_temp;
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// aes_key_schedule: word-serial AES-128/192/256 key expansion into a local
// store, streamed as round keys in encrypt or decrypt order. Revision: 1.0
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [K-1:0]   key,
  output logic           sched_ready,
  input  logic           req_valid,
  input  logic           req_dec,
  output logic           req_ready,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [127:0]   rk_data,
  output logic [3:0]     rk_round,
  output logic           rk_last,
  output logic           busy
);

  localparam int         NK     = nk_of(K);
  localparam int         NR     = nr_of(K);
  localparam int         NW     = 4 * (NR + 1);
  localparam logic [5:0] LAST_W = 6'(NW - 1);
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [2:0] NK_M1  = 3'(NK - 1);
  localparam logic [3:0] NR_R   = 4'(NR);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("aes_key_schedule: K must be 128, 192 or 256");
  end

  ks_state_t    r_state;
  logic [5:0]   r_idx;
  logic [2:0]   r_kpos;   // i mod NK, tracked incrementally
  logic [7:0]   r_rcon;
  logic         r_sched;
  logic         r_dec;
  logic         r_rk_valid;
  logic [127:0] r_rk_data;
  logic [3:0]   r_rk_round;
  logic         r_rk_last;

  word_t        r_store [NW];

  kx_mode_t     w_mode;
  word_t        w_new;
  logic         w_key_acc;
  logic         w_next_dec;
  logic [3:0]   w_next_round;
  logic         w_next_last;
  logic [127:0] w_next_row;

  assign w_key_acc   = (r_state == KS_IDLE) && key_valid;
  assign key_ready   = (r_state == KS_IDLE);
  assign req_ready   = (r_state == KS_IDLE) && r_sched;
  assign busy        = (r_state != KS_IDLE);
  assign sched_ready = r_sched;
  assign rk_valid    = r_rk_valid;
  assign rk_data     = r_rk_data;
  assign rk_round    = r_rk_round;
  assign rk_last     = r_rk_last;

  always_comb begin
    w_mode = PLAIN;
    if (r_kpos == 3'd0)
      w_mode = ROTSUB_RCON;
    else if ((NK == 8) && (r_kpos == 3'd4))
      w_mode = SUB_ONLY;
  end

  aes_kx_word u_kx_word (
    .w_im1  (r_store[r_idx - 6'd1]),
    .w_imnk (r_store[r_idx - NK_W]),
    .rcon   (r_rcon),
    .mode   (w_mode),
    .w_i    (w_new)
  );

  // In IDLE the "next" beat is the first one of the request being accepted.
  always_comb begin
    w_next_dec   = (r_state == KS_IDLE) ? req_dec : r_dec;
    w_next_round = r_dec ? (r_rk_round - 4'd1) : (r_rk_round + 4'd1);
    if (r_state == KS_IDLE)
      w_next_round = req_dec ? NR_R : 4'd0;
    w_next_last  = w_next_dec ? (w_next_round == 4'd0) : (w_next_round == NR_R);
    w_next_row   = {r_store[{w_next_round, 2'b00}], r_store[{w_next_round, 2'b01}],
                    r_store[{w_next_round, 2'b10}], r_store[{w_next_round, 2'b11}]};
  end

  always_ff @(posedge clk) begin
    if (w_key_acc) begin
      for (int j = 0; j < NK; j++)
        r_store[j] <= key[K-1-32*j -: 32];
    end else if (r_state == KS_GEN) begin
      r_store[r_idx] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= KS_IDLE;
      r_idx      <= 6'd0;
      r_kpos     <= 3'd0;
      r_rcon     <= RCON_INIT;
      r_sched    <= 1'b0;
      r_dec      <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= 128'd0;
      r_rk_round <= 4'd0;
      r_rk_last  <= 1'b0;
    end else begin
      case (r_state)
        KS_IDLE: begin
          if (key_valid) begin
            r_state <= KS_GEN;
            r_idx   <= NK_W;
            r_kpos  <= 3'd0;
            r_rcon  <= RCON_INIT;
            r_sched <= 1'b0;
          end else if (req_valid && r_sched) begin
            r_state    <= KS_STREAM;
            r_dec      <= req_dec;
            r_rk_valid <= 1'b1;
            r_rk_round <= w_next_round;
            r_rk_data  <= w_next_row;
            r_rk_last  <= w_next_last;
          end
        end
        KS_GEN: begin
          r_idx  <= r_idx + 6'd1;
          r_kpos <= (r_kpos == NK_M1) ? 3'd0 : (r_kpos + 3'd1);
          if (w_mode == ROTSUB_RCON)
            r_rcon <= xtime(r_rcon);
          if (r_idx == LAST_W) begin
            r_state <= KS_IDLE;
            r_sched <= 1'b1;
          end
        end
        KS_STREAM: begin
          if (rk_ready) begin
            if (r_rk_last) begin
              r_rk_valid <= 1'b0;
              r_state    <= KS_IDLE;
            end else begin
              r_rk_round <= w_next_round;
              r_rk_data  <= w_next_row;
              r_rk_last  <= w_next_last;
            end
          end
        end
        default: r_state <= KS_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// tb_aes_key_schedule: checks K=128/192/256 instances against a GF(2^8)
// arithmetic key-expansion model and the FIPS-197 appendix A vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         kv [3];
  logic         rv [3];
  logic         rdec [3];
  logic         rkr [3];
  logic [255:0] keyb [3];
  logic         kr [3];
  logic         sr [3];
  logic         rqr [3];
  logic         rkv [3];
  logic         lst [3];
  logic         bsy [3];
  logic [127:0] rkd [3];
  logic [3:0]   rnd [3];

  int n_err = 0;
  int n_chk = 0;

  logic [7:0]  sref [256];
  logic [31:0] refw [3][60];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_key_schedule #(.K(128 + 64 * g)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .key_valid   (kv[g]),
      .key_ready   (kr[g]),
      .key         (keyb[g][128+64*g-1:0]),
      .sched_ready (sr[g]),
      .req_valid   (rv[g]),
      .req_dec     (rdec[g]),
      .req_ready   (rqr[g]),
      .rk_valid    (rkv[g]),
      .rk_ready    (rkr[g]),
      .rk_data     (rkd[g]),
      .rk_round    (rnd[g]),
      .rk_last     (lst[g]),
      .busy        (bsy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sref[w[31:24]], sref[w[23:16]], sref[w[15:8]], sref[w[7:0]]};
  endfunction

  task automatic expand_ref(input int d, input logic [255:0] k);
    int nk, nr;
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * d;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) refw[d][i] = k[32*nk-1-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = refw[d][i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      refw[d][i] = refw[d][i-nk] ^ t;
    end
  endtask

  // Presents a key and measures the GEN length until sched_ready.
  task automatic load_key(input int d, input logic [255:0] k);
    int n;
    int exp_gen;
    exp_gen = 4 * (4 + 2 * d + 6 + 1) - (4 + 2 * d);
    expand_ref(d, k);
    keyb[d] = k;
    kv[d] = 1'b1;
    n_chk++;
    if (kr[d] !== 1'b1) begin
      n_err++;
      $display("FAIL key_ready d=%0d got=%b exp=1", d, kr[d]);
    end
    @(posedge clk); #1;
    kv[d] = 1'b0;
    n_chk++;
    if (sr[d] !== 1'b0 || bsy[d] !== 1'b1 || kr[d] !== 1'b0) begin
      n_err++;
      $display("FAIL gen_entry d=%0d sched_ready=%b busy=%b key_ready=%b exp 0/1/0", d, sr[d], bsy[d], kr[d]);
    end
    n = 0;
    while (sr[d] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (n != exp_gen) begin
      n_err++;
      $display("FAIL gen_cycles d=%0d got=%0d exp=%0d", d, n, exp_gen);
    end
  endtask

  // Consumes one stream whose request was accepted on the previous edge.
  task automatic run_beats(input int d, input bit dec, input bit bp,
                           output logic [127:0] first, output logic [127:0] last);
    int nr, e, r;
    bit hs;
    logic [127:0] expd;
    nr = 4 + 2 * d + 6;
    e = 0;
    first = '0;
    last = '0;
    n_chk++;
    if (rkv[d] !== 1'b1) begin
      n_err++;
      $display("FAIL first_valid d=%0d got=%b exp=1", d, rkv[d]);
    end
    for (int cyc = 0; cyc < 400 && e <= nr; cyc++) begin
      r = dec ? nr - e : e;
      expd = {refw[d][4*r], refw[d][4*r+1], refw[d][4*r+2], refw[d][4*r+3]};
      if (rkv[d] === 1'b1) begin
        n_chk++;
        if (rkd[d] !== expd || rnd[d] !== 4'(r) || lst[d] !== (e == nr)) begin
          n_err++;
          $display("FAIL beat d=%0d e=%0d got round=%0d last=%b data=%h exp round=%0d last=%b data=%h",
                   d, e, rnd[d], lst[d], rkd[d], r, (e == nr), expd);
        end
        if (e == 0) first = rkd[d];
        if (e == nr) last = rkd[d];
      end else if (!bp) begin
        n_chk++;
        n_err++;
        $display("FAIL throughput d=%0d e=%0d rk_valid=0 exp=1", d, e);
      end
      rkr[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = (rkv[d] === 1'b1) && rkr[d];
      @(posedge clk); #1;
      if (hs) e++;
    end
    rkr[d] = 1'b0;
    n_chk++;
    if (e != nr + 1 || rkv[d] !== 1'b0 || sr[d] !== 1'b1 || bsy[d] !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end d=%0d beats=%0d rk_valid=%b sched=%b busy=%b exp %0d/0/1/0",
               d, e, rkv[d], sr[d], bsy[d], nr + 1);
    end
  endtask

  task automatic stream(input int d, input bit dec, input bit bp,
                        output logic [127:0] first, output logic [127:0] last);
    n_chk++;
    if (rqr[d] !== 1'b1) begin
      n_err++;
      $display("FAIL req_ready d=%0d got=%b exp=1", d, rqr[d]);
    end
    rv[d] = 1'b1;
    rdec[d] = dec;
    @(posedge clk); #1;
    rv[d] = 1'b0;
    run_beats(d, dec, bp, first, last);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (kr[d] !== 1'b1 || sr[d] !== 1'b0 || rqr[d] !== 1'b0 || rkv[d] !== 1'b0 ||
          rkd[d] !== 128'd0 || rnd[d] !== 4'd0 || lst[d] !== 1'b0 || bsy[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset d=%0d kr=%b sr=%b rqr=%b rkv=%b data=%h rnd=%0d last=%b busy=%b exp 1/0/0/0/0/0/0/0",
                 d, kr[d], sr[d], rqr[d], rkv[d], rkd[d], rnd[d], lst[d], bsy[d]);
      end
    end
  endtask

  task automatic test_fips128();
    logic [127:0] f, l;
    load_key(0, {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
    stream(0, 1'b0, 1'b0, f, l);
    n_chk++;
    if (f !== 128'h2b7e151628aed2a6abf7158809cf4f3c || l !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_err++;
      $display("FAIL fips128_enc got first=%h last=%h exp first=2b7e...4f3c last=d014...0ca6", f, l);
    end
  endtask

  task automatic test_replay_dec();
    logic [127:0] f, l;
    stream(0, 1'b1, 1'b0, f, l);
    n_chk++;
    if (f !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || l !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      n_err++;
      $display("FAIL fips128_dec_replay got first=%h last=%h exp first=d014...0ca6 last=2b7e...4f3c", f, l);
    end
  endtask

  task automatic test_fips192_256();
    logic [127:0] f, l;
    load_key(1, {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b});
    stream(1, 1'b0, 1'b0, f, l);
    n_chk++;
    if (l !== 128'he98ba06f448c773c8ecc720401002202) begin
      n_err++;
      $display("FAIL fips192_round12 got=%h exp=e98ba06f448c773c8ecc720401002202", l);
    end
    load_key(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    stream(2, 1'b0, 1'b0, f, l);
    n_chk++;
    if (l !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      n_err++;
      $display("FAIL fips256_round14 got=%h exp=fe4890d1e6188d0b046df344706c631e", l);
    end
  endtask

  task automatic test_backpressure_random();
    logic [127:0] f, l;
    logic [255:0] k;
    for (int it = 0; it < 2; it++) begin
      for (int d = 0; d < 3; d++) begin
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        load_key(d, k);
        stream(d, 1'($urandom_range(0, 1)), 1'b1, f, l);
        stream(d, 1'($urandom_range(0, 1)), 1'b1, f, l);
      end
    end
  endtask

  task automatic test_reset_mid_gen();
    logic [127:0] f, l;
    logic [255:0] k;
    int n;
    keyb[0] = {128'h0, $urandom, $urandom, $urandom, $urandom};
    kv[0] = 1'b1;
    @(posedge clk); #1;
    kv[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++;
    if (sr[0] !== 1'b0 || rkv[0] !== 1'b0 || kr[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_gen_reset sr=%b rkv=%b kr=%b busy=%b exp 0/0/1/0", sr[0], rkv[0], kr[0], bsy[0]);
    end
    k = {128'h0, $urandom, $urandom, $urandom, $urandom};
    expand_ref(0, k);
    keyb[0] = k;
    kv[0] = 1'b1;
    rv[0] = 1'b1;
    rdec[0] = 1'b0;
    @(posedge clk); #1;
    kv[0] = 1'b0;
    n = 0;
    while (sr[0] !== 1'b1 && n < 200) begin
      n_chk++;
      if (rkv[0] !== 1'b0 || rqr[0] !== 1'b0) begin
        n_err++;
        $display("FAIL pending_req n=%0d rkv=%b rqr=%b exp 0/0", n, rkv[0], rqr[0]);
      end
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (n != 40) begin
      n_err++;
      $display("FAIL gen_cycles_after_reset got=%0d exp=40", n);
    end
    @(posedge clk); #1;
    rv[0] = 1'b0;
    run_beats(0, 1'b0, 1'b0, f, l);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      kv[d] = 1'b0; rv[d] = 1'b0; rdec[d] = 1'b0; rkr[d] = 1'b0; keyb[d] = '0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_fips128();
    test_replay_dec();
    test_fips192_256();
    test_backpressure_random();
    test_reset_mid_gen();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
